// File: rtl/accum_pkg.sv
// Shared types and default widths for the packet accumulator stage.
package accum_pkg;

    localparam int N_DEF  = 4;
    localparam int CW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : accum_pkg

// File: rtl/accum_stage_if.sv
// Operand-in / result-out handshake bundle for accum_stage.
interface accum_stage_if
    import accum_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_sum;
    logic          out_ovf;
    logic [CW-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_count
    );

endinterface : accum_stage_if

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];

endmodule : ripple_carry_adder

// File: rtl/accum_stage.sv
// Sums the beats of a packet, tracks carry-out and beat count, and holds the
// result until downstream takes it.
module accum_stage
    import accum_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    accum_stage_if.slave  bus
);

    state_t        state, state_nxt;
    logic [N-1:0]  acc,   acc_nxt;
    logic          ovf,   ovf_nxt;
    logic [CW-1:0] count, count_nxt;

    logic [N-1:0]  add_sum;
    logic          add_cout;
    logic          accept;

    ripple_carry_adder #(.N(N)) u_adder (
        .a    (acc),
        .b    (bus.in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign bus.in_ready  = (state != HOLD);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign bus.out_count = count;

    assign accept = bus.in_valid && bus.in_ready;

    // NOTE: every next-state signal gets its hold value first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        count_nxt = count;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = bus.in_data;
                    ovf_nxt   = 1'b0;
                    count_nxt = CW'(1);
                    state_nxt = bus.in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt   = add_sum;
                    ovf_nxt   = ovf | add_cout;
                    count_nxt = (count == '1) ? count : count + CW'(1);
                    state_nxt = bus.in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                // Result registers stay put so the next packet's first beat
                // is the only thing that clears them.
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from the values sampled before the edge.
    // NOTE: the whole datapath is reset (no memories here), so an aborted
    // packet never leaks a partial sum into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            count <= count_nxt;
        end
    end

endmodule : accum_stage

// File: tb/tb_accum_stage.sv
// Directed bench for accum_stage: a packet-level sum model checked every
// cycle, plus hand-computed expectations at the key points.
module tb_accum_stage;

    localparam int N  = 4;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_vec  = 0;
    int n_fail = 0;

    accum_stage_if #(.N(N), .CW(CW)) bus ();

    accum_stage #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: beats of the current (or last finished) packet.
    int unsigned pkt[$];
    bit          m_hold = 1'b0;
    bit          m_open = 1'b0;

    function automatic longint unsigned pkt_total();
        longint unsigned t = 0;
        foreach (pkt[i]) t += pkt[i];
        return t;
    endfunction

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pkt.delete();
                m_hold = 1'b0;
                m_open = 1'b0;
            end else if (!m_hold) begin
                if (bus.in_valid) begin
                    if (!m_open) pkt.delete();
                    pkt.push_back(int'(bus.in_data));
                    m_hold = bus.in_last;
                    m_open = !bus.in_last;
                end
            end else if (bus.out_ready) begin
                m_hold = 1'b0;
            end
        end
    end

    initial begin : compare
        longint unsigned total;
        int unsigned     cnt;
        forever begin
            @(negedge clk);
            total = pkt_total();
            cnt   = (pkt.size() > 255) ? 255 : pkt.size();
            check("out_valid", 32'(bus.out_valid), 32'(m_hold));
            check("in_ready",  32'(bus.in_ready),  32'(!m_hold));
            check("out_sum",   32'(bus.out_sum),   32'(total % 16));
            check("out_ovf",   32'(bus.out_ovf),   32'(total >= 16));
            check("out_count", 32'(bus.out_count), cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [N-1:0] d, input logic last);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (waited >= 20) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic expect_result(input string tag, input logic [3:0] s,
                                 input logic o, input logic [7:0] c);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_sum"},   32'(bus.out_sum),   32'(s));
        check({tag, "_ovf"},   32'(bus.out_ovf),   32'(o));
        check({tag, "_count"}, 32'(bus.out_count), 32'(c));
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("handoff_valid", 32'(bus.out_valid), 32'd0);
        check("handoff_ready", 32'(bus.in_ready),  32'd1);
    endtask

    initial begin : stimulus
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",   32'(bus.out_sum),   32'd0);
        check("rst_ovf",   32'(bus.out_ovf),   32'd0);
        check("rst_count", 32'(bus.out_count), 32'd0);
        check("rst_ready", 32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;
        step();

        // 3 + 5 + 6 = 14, with an idle gap inside the packet
        send_beat(4'd3, 1'b0);
        step();
        send_beat(4'd5, 1'b0);
        send_beat(4'd6, 1'b1);
        expect_result("p356", 4'hE, 1'b0, 8'd3);
        handoff();
        check("retain_sum", 32'(bus.out_sum), 32'hE);

        // 9 + 8 = 17 -> wraps to 1 with carry
        send_beat(4'd9, 1'b0);
        send_beat(4'd8, 1'b1);
        expect_result("p98", 4'h1, 1'b1, 8'd2);
        handoff();

        send_beat(4'd2, 1'b1);
        expect_result("p2", 4'h2, 1'b0, 8'd1);
        handoff();

        // Backpressure with a beat offered the whole time
        send_beat(4'd4, 1'b0);
        send_beat(4'd4, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hF;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_result("bp", 4'h8, 1'b0, 8'd2);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        handoff();
        check("bp_no_accept_count", 32'(bus.out_count), 32'd2);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        step();

        // Reset mid-packet
        send_beat(4'd7, 1'b0);
        send_beat(4'd7, 1'b0);
        check("mid_partial", 32'(bus.out_sum), 32'hE);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_sum",   32'(bus.out_sum),   32'd0);
        check("mid_rst_count", 32'(bus.out_count), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        #1 rst_n = 1'b1;
        step();
        send_beat(4'd1, 1'b0);
        send_beat(4'd1, 1'b1);
        expect_result("p11", 4'h2, 1'b0, 8'd2);
        handoff();

        // Beat-count saturation
        for (int i = 0; i < 300; i++) begin
            send_beat(4'd0, (i == 299));
        end
        expect_result("sat", 4'h0, 1'b0, 8'd255);
        handoff();

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_accum_stage

// File: doc/accum_stage.md
ACCUM_STAGE -- requirements
Module: accum_stage

Interface
- REQ-001 Parameter N, default 4, data and accumulator width in bits.
- REQ-002 Parameter CW, default 8, beat-counter width in bits.
- REQ-003 clk  input  1  single clock; all state updates on the rising edge.
- REQ-004 rst_n  input  1  asynchronous reset, active-low.
- REQ-005 in_valid  input  1  operand beat is valid.
- REQ-006 in_ready  output  1  block accepts an operand beat this cycle.
- REQ-007 in_data  input  N  operand, unsigned.
- REQ-008 in_last  input  1  marks the final beat of a packet; qualified by in_valid.
- REQ-009 out_valid  output  1  result is valid.
- REQ-010 out_ready  input  1  downstream accepts the result.
- REQ-011 out_sum  output  N  packet sum modulo 2^N.
- REQ-012 out_ovf  output  1  sticky flag: some addition in the packet produced a carry-out.
- REQ-013 out_count  output  CW  number of beats in the packet, saturating.

Function
- REQ-014 The block SHALL implement states IDLE, ACCUM and HOLD.
- REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD; it SHALL be decoded combinationally from the state only.
- REQ-016 A beat SHALL be accepted only when in_valid and in_ready are both 1.
- REQ-017 In IDLE, an accepted beat SHALL load acc=in_data, ovf=0 and count=1.
  - Next state SHALL be HOLD if in_last=1, else ACCUM.
- REQ-018 In ACCUM, an accepted beat SHALL update acc and ovf through the adder with cin=0:
  - acc = (acc+in_data) mod 2^N.
  - ovf = ovf OR carry-out.
  - count increments, saturating at 2^CW-1.
  - Next state SHALL be HOLD if in_last=1, else the state stays ACCUM.
- REQ-019 In IDLE and ACCUM, in_valid=0 SHALL leave acc, ovf, count and state unchanged.
- REQ-020 out_valid SHALL be 1 exactly when in HOLD, i.e. one cycle after the last beat is accepted.
- REQ-021 out_sum, out_ovf and out_count SHALL be driven directly from acc, ovf and count, and SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-022 In HOLD, out_ready=1 SHALL return the state to IDLE on the next edge.
  - acc, ovf and count SHALL retain their values until the next packet's first beat.
- REQ-023 In HOLD, in_valid SHALL be ignored; no beat is accepted in the same cycle as result handoff.
- REQ-024 out_valid SHALL NOT depend combinationally on out_ready.

Reset
- REQ-025 rst_n=0 SHALL immediately force state=IDLE, acc=0, ovf=0 and count=0, independent of clk.
- REQ-026 During and after reset, out_valid=0, out_sum=0, out_ovf=0, out_count=0 and in_ready=1.
- REQ-027 Reset asserted mid-packet or in HOLD SHALL discard the partial or pending result; the next accepted beat starts a new packet.

Structure
- REQ-028 Package accum_pkg SHALL hold the state enum typedef (IDLE, ACCUM, HOLD) and the default N/CW constants.
- REQ-029 The addition SHALL instantiate ripple_carry_adder (N=N, cin=0); no other sub-module.
- REQ-030 Registered state SHALL be limited to state, acc, ovf and count.

Verification (N=4, CW=8)
- REQ-031 Reset: hold rst_n=0 for 3 cycles -> out_valid=0, out_sum=0, out_ovf=0, out_count=0, in_ready=1.
- REQ-032 Packet 3, 5, 6 (last on 6) -> one cycle later out_valid=1, out_sum=0xE, out_ovf=0, out_count=3.
- REQ-033 Packet 9, 8 (last on 8) -> out_sum=0x1, out_ovf=1, out_count=2.
  - Then packet 2 (single beat, last) -> out_sum=0x2, out_ovf=0, out_count=1.
- REQ-034 Backpressure: result valid, out_ready=0 for 5 cycles, in_valid=1 throughout -> outputs stable, in_ready=0, no beat accepted.
  - out_ready=1 -> IDLE next cycle.
- REQ-035 Reset mid-packet: after beats 7, 7, pulse rst_n low asynchronously -> outputs zero.
  - Then packet 1, 1 (last) -> out_sum=0x2, out_ovf=0, out_count=2.
- REQ-036 Saturation: 300 beats of 0 with last on the final beat -> out_count=255, out_sum=0, out_ovf=0.
